// File: rtl/mem_row_cache_ctrl.sv
// Row-cache tag controller: maps open-row requests onto 2**CHWIDTH emulation slots with write-back/fill handshakes.
// Optional saturating statistics counters when MEM_ROW_CACHE_STATS_EN is defined.
module mem_row_cache_ctrl #(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 act,
    input  logic                 pr,
    input  logic                 rd,
    input  logic                 wr,
    input  logic                 flush,
    input  logic [ADDRWIDTH-1:0] row_id,
    output logic [CHWIDTH-1:0]   c_row_id,
    output logic                 hit,
    output logic                 ready,
    output logic                 stall,
    output logic                 wb_req,
    output logic [ADDRWIDTH-1:0] wb_row,
    output logic [CHWIDTH-1:0]   wb_slot,
    input  logic                 wb_ack,
    output logic                 fill_req,
    output logic [ADDRWIDTH-1:0] fill_row,
    output logic [CHWIDTH-1:0]   fill_slot,
    input  logic                 fill_ack,
    output logic                 flush_done
`ifdef MEM_ROW_CACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt,
    output logic [31:0]          wb_cnt
`endif
);
    localparam int CHROWS = 1 << CHWIDTH;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, VICTIM, WRITEBACK, FILL, ACTIVE, FLUSH_SCAN, FLUSH_WB
    } state_t;

    state_t state, state_n;

    logic [CHROWS-1:0]    valid, dirty;
    logic [ADDRWIDTH-1:0] rowaddr [CHROWS];
    logic [ADDRWIDTH-1:0] req_row, req_row_n;
    logic [CHWIDTH-1:0]   rr_ptr, rr_ptr_n, scan_idx, scan_idx_n;

    logic [CHWIDTH-1:0]   c_row_id_n, wb_slot_n, fill_slot_n;
    logic [ADDRWIDTH-1:0] wb_row_n, fill_row_n;
    logic                 hit_n, ready_n, stall_n, wb_req_n, fill_req_n, flush_done_n;
    logic                 set_dirty, clr_dirty, fill_commit;

    logic                 hit_any, free_any;
    logic [CHWIDTH-1:0]   hit_slot, free_slot, victim;

    // Scan from the top so the lowest matching / lowest free index is the one left standing.
    always_comb begin
        hit_any   = 1'b0;
        hit_slot  = '0;
        free_any  = 1'b0;
        free_slot = '0;
        for (int unsigned i = 0; i < CHROWS; i++) begin
            if (valid[CHROWS-1-i] && rowaddr[CHROWS-1-i] == req_row) begin
                hit_any  = 1'b1;
                hit_slot = CHWIDTH'(CHROWS-1-i);
            end
            if (!valid[CHROWS-1-i]) begin
                free_any  = 1'b1;
                free_slot = CHWIDTH'(CHROWS-1-i);
            end
        end
        victim = free_any ? free_slot : rr_ptr;
    end

    always_comb begin
        state_n      = state;
        req_row_n    = req_row;
        rr_ptr_n     = rr_ptr;
        scan_idx_n   = scan_idx;
        c_row_id_n   = c_row_id;
        hit_n        = hit;
        ready_n      = 1'b0;
        wb_row_n     = wb_row;
        wb_slot_n    = wb_slot;
        fill_row_n   = fill_row;
        fill_slot_n  = fill_slot;
        flush_done_n = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        fill_commit  = 1'b0;

        case (state)
            IDLE: begin
                if (act || rd || wr) begin
                    req_row_n = row_id;
                    state_n   = LOOKUP;
                end else if (flush) begin
                    scan_idx_n = '0;
                    state_n    = FLUSH_SCAN;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    c_row_id_n = hit_slot;
                    hit_n      = 1'b1;
                    state_n    = ACTIVE;
                end else begin
                    hit_n   = 1'b0;
                    state_n = VICTIM;
                end
            end
            VICTIM: begin
                c_row_id_n  = victim;
                fill_row_n  = req_row;
                fill_slot_n = victim;
                if (!free_any) begin
                    rr_ptr_n = rr_ptr + 1'b1;
                end
                if (dirty[victim]) begin
                    wb_row_n  = rowaddr[victim];
                    wb_slot_n = victim;
                    state_n   = WRITEBACK;
                end else begin
                    state_n = FILL;
                end
            end
            WRITEBACK: begin
                if (wb_ack) begin
                    clr_dirty = 1'b1;
                    state_n   = FILL;
                end
            end
            FILL: begin
                if (fill_ack) begin
                    fill_commit = 1'b1;
                    state_n     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (pr) begin
                    state_n = IDLE;
                end else if (act) begin
                    req_row_n = row_id;
                    state_n   = LOOKUP;
                end else if (rd || wr) begin
                    ready_n   = 1'b1;
                    set_dirty = wr;
                end
            end
            FLUSH_SCAN: begin
                if (valid[scan_idx] && dirty[scan_idx]) begin
                    wb_row_n  = rowaddr[scan_idx];
                    wb_slot_n = scan_idx;
                    state_n   = FLUSH_WB;
                end else if (scan_idx == '1) begin
                    flush_done_n = 1'b1;
                    state_n      = IDLE;
                end else begin
                    scan_idx_n = scan_idx + 1'b1;
                end
            end
            FLUSH_WB: begin
                if (wb_ack) begin
                    clr_dirty = 1'b1;
                    if (scan_idx == '1) begin
                        flush_done_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        scan_idx_n = scan_idx + 1'b1;
                        state_n    = FLUSH_SCAN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Handshake and stall outputs are registered views of the state being entered.
        wb_req_n   = (state_n == WRITEBACK) || (state_n == FLUSH_WB);
        fill_req_n = (state_n == FILL);
        stall_n    = (state_n == VICTIM) || (state_n == WRITEBACK) || (state_n == FILL) ||
                     (state_n == FLUSH_SCAN) || (state_n == FLUSH_WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_row    <= '0;
            rr_ptr     <= '0;
            scan_idx   <= '0;
            c_row_id   <= '0;
            hit        <= 1'b0;
            ready      <= 1'b0;
            stall      <= 1'b0;
            wb_req     <= 1'b0;
            wb_row     <= '0;
            wb_slot    <= '0;
            fill_req   <= 1'b0;
            fill_row   <= '0;
            fill_slot  <= '0;
            flush_done <= 1'b0;
            valid      <= '0;
            dirty      <= '0;
            for (int unsigned i = 0; i < CHROWS; i++) begin
                rowaddr[i] <= '0;
            end
        end else begin
            state      <= state_n;
            req_row    <= req_row_n;
            rr_ptr     <= rr_ptr_n;
            scan_idx   <= scan_idx_n;
            c_row_id   <= c_row_id_n;
            hit        <= hit_n;
            ready      <= ready_n;
            stall      <= stall_n;
            wb_req     <= wb_req_n;
            wb_row     <= wb_row_n;
            wb_slot    <= wb_slot_n;
            fill_req   <= fill_req_n;
            fill_row   <= fill_row_n;
            fill_slot  <= fill_slot_n;
            flush_done <= flush_done_n;
            if (set_dirty) begin
                dirty[c_row_id] <= 1'b1;
            end
            if (clr_dirty) begin
                dirty[wb_slot] <= 1'b0;
            end
            if (fill_commit) begin
                valid[fill_slot]   <= 1'b1;
                dirty[fill_slot]   <= 1'b0;
                rowaddr[fill_slot] <= req_row;
            end
        end
    end

`ifdef MEM_ROW_CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state == LOOKUP && hit_any && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (state == LOOKUP && !hit_any && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if ((state == WRITEBACK || state == FLUSH_WB) && wb_ack && wb_cnt != '1) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_row_cache_ctrl.sv
// Scoreboard bench for mem_row_cache_ctrl: a slot-table model predicts write-back/fill/ready/flush_done events.
module tb_mem_row_cache_ctrl;
    localparam int CW = 2;
    localparam int AW = 8;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst, act, pr, rd, wr, flush, wb_ack, fill_ack;
    logic [AW-1:0] row_id;
    logic [CW-1:0] c_row_id, wb_slot, fill_slot;
    logic [AW-1:0] wb_row, fill_row;
    logic          hit, ready, stall, wb_req, fill_req, flush_done;

    always #5 clk = ~clk;

    mem_row_cache_ctrl #(.CHWIDTH(CW), .ADDRWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .act(act), .pr(pr), .rd(rd), .wr(wr), .flush(flush),
        .row_id(row_id), .c_row_id(c_row_id), .hit(hit), .ready(ready), .stall(stall),
        .wb_req(wb_req), .wb_row(wb_row), .wb_slot(wb_slot), .wb_ack(wb_ack),
        .fill_req(fill_req), .fill_row(fill_row), .fill_slot(fill_slot), .fill_ack(fill_ack),
        .flush_done(flush_done)
    );

    typedef struct packed {
        logic [AW-1:0] row;
        logic [CW-1:0] slot;
    } req_t;

    req_t        wb_q[$], fill_q[$];
    int unsigned exp_ready = 0, exp_done = 0;
    int unsigned errors = 0, checks = 0;

    // Reference model: slot table plus round-robin pointer.
    bit          m_valid[NS], m_dirty[NS];
    logic [AW-1:0] m_row[NS];
    int unsigned m_rr, m_slot;
    bit          m_active;

    int unsigned wdelay = 1, fdelay = 1;
    bit          hold_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expv);
        checks++;
        if (actual !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expv, $time);
        end
    endtask

    function automatic req_t mk(input logic [AW-1:0] r, input int unsigned s);
        req_t t;
        t.row  = r;
        t.slot = CW'(s);
        return t;
    endfunction

    task automatic model_clear();
        for (int unsigned i = 0; i < NS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_row[i]   = '0;
        end
        m_rr = 0;
        m_slot = 0;
        m_active = 1'b0;
    endtask

    // Backing-store mover: acks each request after the currently configured delay.
    initial begin
        int unsigned wcnt = 0, fcnt = 0;
        wb_ack = 1'b0;
        fill_ack = 1'b0;
        forever begin
            @(negedge clk);
            wb_ack = 1'b0;
            fill_ack = 1'b0;
            if (rst) begin
                wcnt = 0;
                fcnt = 0;
            end else begin
                if (wb_req) begin
                    if (wcnt >= wdelay) begin wb_ack = 1'b1; wcnt = 0; end
                    else wcnt++;
                end else wcnt = 0;
                if (fill_req && !hold_ack) begin
                    if (fcnt >= fdelay) begin fill_ack = 1'b1; fcnt = 0; end
                    else fcnt++;
                end else fcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a request or pulse.
    initial begin
        logic          p_wb = 1'b0, p_fill = 1'b0;
        logic [AW-1:0] p_wrow = '0, p_frow = '0;
        logic [CW-1:0] p_wslot = '0, p_fslot = '0;
        req_t          e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wb_req && !p_wb) begin
                    chk("wb_expected", 32'(wb_q.size() != 0), 32'd1);
                    if (wb_q.size() != 0) begin
                        e = wb_q.pop_front();
                        chk("wb_row", 32'(wb_row), 32'(e.row));
                        chk("wb_slot", 32'(wb_slot), 32'(e.slot));
                    end
                end else if (wb_req) begin
                    chk("wb_row_stable", 32'(wb_row), 32'(p_wrow));
                    chk("wb_slot_stable", 32'(wb_slot), 32'(p_wslot));
                end
                if (fill_req && !p_fill) begin
                    chk("fill_expected", 32'(fill_q.size() != 0), 32'd1);
                    if (fill_q.size() != 0) begin
                        e = fill_q.pop_front();
                        chk("fill_row", 32'(fill_row), 32'(e.row));
                        chk("fill_slot", 32'(fill_slot), 32'(e.slot));
                    end
                end else if (fill_req) begin
                    chk("fill_row_stable", 32'(fill_row), 32'(p_frow));
                    chk("fill_slot_stable", 32'(fill_slot), 32'(p_fslot));
                end
                if (ready) begin
                    chk("ready_expected", 32'(exp_ready != 0), 32'd1);
                    if (exp_ready != 0) exp_ready--;
                end
                if (flush_done) begin
                    chk("flush_done_expected", 32'(exp_done != 0), 32'd1);
                    if (exp_done != 0) exp_done--;
                end
            end
            p_wb = wb_req; p_wrow = wb_row; p_wslot = wb_slot;
            p_fill = fill_req; p_frow = fill_row; p_fslot = fill_slot;
        end
    end

    task automatic idle_inputs();
        act = 1'b0; pr = 1'b0; rd = 1'b0; wr = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        chk("pending_wb", 32'(wb_q.size()), 32'd0);
        chk("pending_fill", 32'(fill_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_ready = 0;
        exp_done = 0;
    endtask

    task automatic open_row(input logic [AW-1:0] r, input bit with_flush);
        int s = -1;
        int v = -1;
        int unsigned n = 0;
        for (int unsigned i = 0; i < NS; i++)
            if (s < 0 && m_valid[i] && m_row[i] == r) s = int'(i);
        @(negedge clk);
        act = 1'b1; flush = with_flush; row_id = r;
        @(negedge clk);
        act = 1'b0; flush = 1'b0;
        if (s >= 0) begin
            @(negedge clk);
            chk("hit", 32'(hit), 32'd1);
            chk("hit_slot", 32'(c_row_id), 32'(s));
            chk("hit_stall", 32'(stall), 32'd0);
            m_slot = int'(s);
        end else begin
            for (int unsigned i = 0; i < NS; i++)
                if (v < 0 && !m_valid[i]) v = int'(i);
            if (v < 0) begin
                v = int'(m_rr);
                m_rr = (m_rr + 1) % NS;
            end
            if (m_dirty[v]) wb_q.push_back(mk(m_row[v], v));
            fill_q.push_back(mk(r, v));
            @(negedge clk);
            chk("miss_stall", 32'(stall), 32'd1);
            chk("miss_hit", 32'(hit), 32'd0);
            while (stall && n < 64) begin
                @(negedge clk);
                n++;
            end
            chk("miss_in_time", 32'(n < 64), 32'd1);
            chk("miss_hit_after", 32'(hit), 32'd0);
            chk("victim_slot", 32'(c_row_id), 32'(v));
            m_valid[v] = 1'b1;
            m_row[v] = r;
            m_dirty[v] = 1'b0;
            m_slot = int'(v);
        end
        m_active = 1'b1;
    endtask

    task automatic access(input bit is_wr, input bit both);
        @(negedge clk);
        rd = !is_wr || both;
        wr = is_wr || both;
        exp_ready++;
        if (is_wr || both) m_dirty[m_slot] = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        chk("ready_pulse", 32'(ready), 32'd1);
        @(negedge clk);
        chk("ready_single", 32'(ready), 32'd0);
    endtask

    task automatic close_row();
        @(negedge clk);
        pr = 1'b1;
        @(negedge clk);
        pr = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic do_flush(output int unsigned n);
        for (int unsigned i = 0; i < NS; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                wb_q.push_back(mk(m_row[i], i));
                m_dirty[i] = 1'b0;
            end
        end
        exp_done++;
        n = 0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (!flush_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done_seen", 32'(flush_done), 32'd1);
        @(negedge clk);
        chk("flush_stall_low", 32'(stall), 32'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned op;
        rst = 1'b1;
        idle_inputs();
        row_id = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_c_row_id", 32'(c_row_id), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_req", 32'(wb_req), 32'd0);
        chk("rst_fill_req", 32'(fill_req), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        rst = 1'b0;

        // Cold miss then hit with a read.
        fdelay = 3;
        open_row(8'h11, 1'b0);
        close_row();
        open_row(8'h11, 1'b0);
        access(1'b0, 1'b0);

        // Dirty eviction through the round-robin pointer.
        do_reset();
        wdelay = 2; fdelay = 1;
        for (int unsigned i = 0; i < NS; i++) begin
            open_row(AW'(8'h10 + i), 1'b0);
            access(1'b1, 1'b0);
        end
        open_row(8'h20, 1'b0);
        open_row(8'h21, 1'b0);

        // Flush with slots 1 and 3 dirty, then a clean flush.
        do_reset();
        for (int unsigned i = 0; i < NS; i++) begin
            open_row(AW'(8'h10 + i), 1'b0);
            if (i == 1 || i == 3) access(1'b1, 1'b0);
        end
        close_row();
        do_flush(n);
        do_flush(n);
        chk("clean_flush_cycles", 32'(n), 32'(NS));
        for (int unsigned i = 0; i < NS; i++) open_row(AW'(8'h10 + i), 1'b0);

        // Priority: act beats flush in IDLE, pr beats rd in ACTIVE.
        access(1'b1, 1'b1);
        close_row();
        open_row(8'h12, 1'b1);
        @(negedge clk);
        pr = 1'b1; rd = 1'b1;
        @(negedge clk);
        pr = 1'b0; rd = 1'b0;
        m_active = 1'b0;
        chk("pr_rd_no_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("pr_rd_no_ready_late", 32'(ready), 32'd0);
        do_flush(n);

        // Reset while a fill is outstanding.
        do_reset();
        hold_ack = 1'b1;
        fill_q.push_back(mk(8'h33, 0));
        @(negedge clk);
        act = 1'b1; row_id = 8'h33;
        @(negedge clk);
        act = 1'b0;
        n = 0;
        while (!fill_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fill_req_before_rst", 32'(fill_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_fill_req", 32'(fill_req), 32'd0);
        chk("rst_drops_stall", 32'(stall), 32'd0);
        hold_ack = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        open_row(8'h33, 1'b0);

        // Randomised traffic over six rows competing for four slots.
        for (int unsigned k = 0; k < 80; k++) begin
            wdelay = $urandom_range(0, 3);
            fdelay = $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            if (!m_active) begin
                if (op < 6) open_row(AW'(8'h10 + $urandom_range(0, 5)), 1'b0);
                else if (op < 8) do_flush(n);
                else @(negedge clk);
            end else begin
                if (op < 4) access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else if (op < 6) open_row(AW'(8'h10 + $urandom_range(0, 5)), 1'b0);
                else if (op < 8) close_row();
                else @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        chk("fill_q_drained", 32'(fill_q.size()), 32'd0);
        chk("ready_drained", 32'(exp_ready), 32'd0);
        chk("done_drained", 32'(exp_done), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
